adder_axis_multi: RTL and testbench

Parametrised N-channel AXI-Stream adder, successor to the two-input naive adder. Each input channel is buffered in its own FIFO, so a channel can run ahead of the others by up to DEPTH beats. When every channel holds at least one beat, one beat is popped from each and their sum is emitted through a registered output stage with full backpressure. The adder also offers a selectable wrap-free or saturating output mode.

---
 rtl/adder_axis_pkg.sv | 12 +
 rtl/axis_fifo_sync.sv | 58 +++++
 rtl/adder_axis_multi.sv | 92 +++++++++
 tb/tb_adder_axis_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_axis_pkg.sv
// Shared definitions for the N-channel AXI-Stream adder: output mode constants
// and the output width rule.
package adder_axis_pkg;

  localparam int SAT_OFF = 0;
  localparam int SAT_ON  = 1;

  function automatic int out_width(input int width, input int n_ch, input int sat);
    return (sat == SAT_ON) ? width : width + $clog2(n_ch);
  endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Single-clock FIFO with registered occupancy count; one instance per input
// channel of the adder.
module axis_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read when
  // the count says they were written, so clearing them would buy nothing.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adder_axis_multi.sv
// N-channel AXI-Stream adder: per-channel FIFOs, lock-step pop of one beat per
// channel, optional saturation, registered output with backpressure.
module adder_axis_multi
  import adder_axis_pkg::*;
#(
  parameter int  N_CH  = 2,
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  parameter int  SAT   = 0,
  localparam int OUT_W = out_width(WIDTH, N_CH, SAT)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [N_CH*WIDTH-1:0] data_i_tdata,
  input  logic [N_CH-1:0]       data_i_tvalid,
  output logic [N_CH-1:0]       data_i_tready,
  output logic [OUT_W-1:0]      data_o_tdata,
  output logic                  data_o_tvalid,
  input  logic                  data_o_tready,
  output logic                  data_o_tuser
);

  localparam int SUM_W = WIDTH + $clog2(N_CH);
  localparam logic [SUM_W-1:0] MAX_OUT = SUM_W'({WIDTH{1'b1}});

  logic             in_en;
  logic [N_CH-1:0]  full;
  logic [N_CH-1:0]  empty;
  logic [N_CH-1:0]  push;
  logic [WIDTH-1:0] head [N_CH];
  logic             pop;
  logic [SUM_W-1:0] sum;
  logic [OUT_W-1:0] result;
  logic             sat_flag;

  // Holds tready low through reset and releases it on the first edge after.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) in_en <= 1'b0;
    else         in_en <= 1'b1;
  end

  assign data_i_tready = in_en ? ~full : '0;
  assign push          = data_i_tvalid & data_i_tready;
  assign pop           = (&(~empty)) && (!data_o_tvalid || data_o_tready);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    axis_fifo_sync #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (push[c]),
      .pop     (pop),
      .din     (data_i_tdata[c*WIDTH +: WIDTH]),
      .dout    (head[c]),
      .full    (full[c]),
      .empty   (empty[c])
    );
  end

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum = '0;
    for (int c = 0; c < N_CH; c++) sum = sum + SUM_W'(head[c]);
  end

  always_comb begin
    sat_flag = 1'b0;
    result   = sum[OUT_W-1:0];
    if (SAT == SAT_ON && sum > MAX_OUT) begin
      sat_flag = 1'b1;
      result   = '1;
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      data_o_tdata  <= '0;
      data_o_tuser  <= 1'b0;
      data_o_tvalid <= 1'b0;
    end else if (pop) begin
      data_o_tdata  <= result;
      data_o_tuser  <= sat_flag;
      data_o_tvalid <= 1'b1;
    end else if (data_o_tready) begin
      data_o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_axis_multi.sv
// Directed and random bench for adder_axis_multi: two instances (full-growth and
// saturating) share one stimulus; a per-channel model feeds an expected-sum queue.
module tb_adder_axis_multi;

  logic        aclk;
  logic        aresetn;
  logic [23:0] i_tdata;
  logic [2:0]  i_tvalid;
  logic [2:0]  i_tready0;
  logic [2:0]  i_tready1;
  logic [9:0]  o_tdata0;
  logic [7:0]  o_tdata1;
  logic        o_tvalid0;
  logic        o_tvalid1;
  logic        o_tuser0;
  logic        o_tuser1;
  logic        o_tready;

  adder_axis_multi #(.N_CH(3), .WIDTH(8), .DEPTH(4), .SAT(0)) u_dut0 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .data_i_tdata  (i_tdata),
    .data_i_tvalid (i_tvalid),
    .data_i_tready (i_tready0),
    .data_o_tdata  (o_tdata0),
    .data_o_tvalid (o_tvalid0),
    .data_o_tready (o_tready),
    .data_o_tuser  (o_tuser0)
  );

  adder_axis_multi #(.N_CH(3), .WIDTH(8), .DEPTH(4), .SAT(1)) u_dut1 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .data_i_tdata  (i_tdata),
    .data_i_tvalid (i_tvalid),
    .data_i_tready (i_tready1),
    .data_o_tdata  (o_tdata1),
    .data_o_tvalid (o_tvalid1),
    .data_o_tready (o_tready),
    .data_o_tuser  (o_tuser1)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         out_cnt  = 0;
  logic [7:0] chq [3][$];
  int         exp_q [$];

  // Values sampled at the falling edge of the most recent cycle.
  logic [2:0] rdy_s;
  logic       ov_s;
  logic [9:0] od0_s;
  logic [7:0] od1_s;
  logic       ou0_s;
  logic       ou1_s;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sat8(input int s);
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // One clock of stimulus: drive at posedge+1, sample at negedge, model the
  // handshakes that the coming posedge will complete.
  task automatic cycle(input logic [2:0] v, input logic [23:0] d, input logic ordy,
                       output logic [2:0] hs);
    int s;
    i_tvalid = v;
    i_tdata  = d;
    o_tready = ordy;
    @(negedge aclk);
    rdy_s = i_tready0;
    ov_s  = o_tvalid0;
    od0_s = o_tdata0;
    od1_s = o_tdata1;
    ou0_s = o_tuser0;
    ou1_s = o_tuser1;
    hs    = aresetn ? 3'b000 : (v & i_tready0);
    for (int c = 0; c < 3; c++) if (hs[c]) chq[c].push_back(d[c*8 +: 8]);
    while (chq[0].size() > 0 && chq[1].size() > 0 && chq[2].size() > 0) begin
      s = chq[0].pop_front() + chq[1].pop_front() + chq[2].pop_front();
      exp_q.push_back(s);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    logic [2:0] hs;
    int n = 0;
    while ((exp_q.size() != 0 || o_tvalid0) && n < 50) begin
      cycle(3'b000, 24'd0, 1'b1, hs);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Output scoreboard: a beat is consumed when valid and ready meet.
  always @(negedge aclk) begin
    if (!aresetn && o_tvalid0 && o_tready) begin
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        chk("sum_full", o_tdata0, e);
        chk("user_full", o_tuser0, 0);
        chk("sum_sat", o_tdata1, sat8(e));
        chk("user_sat", o_tuser1, e > 255);
        out_cnt++;
      end
    end
  end

  initial begin
    logic [2:0] hs;
    logic [2:0] pend;
    logic [7:0] pdat [3];
    int         sent [3];
    int         base;
    int         cyc;

    aresetn  = 1'b1;
    i_tvalid = '0;
    i_tdata  = '0;
    o_tready = 1'b0;
    @(posedge aclk);
    #1;

    // Reset held with random traffic.
    for (int i = 0; i < 10; i++) begin
      cycle(3'($urandom), 24'($urandom), 1'($urandom), hs);
      chk("rst_tready", rdy_s, 3'b000);
      chk("rst_tvalid", ov_s, 0);
      chk("rst_tdata0", od0_s, 0);
      chk("rst_tdata1", od1_s, 0);
      chk("rst_tuser1", ou1_s, 0);
    end
    aresetn = 1'b0;
    cycle(3'b000, 24'd0, 1'b1, hs);
    cycle(3'b000, 24'd0, 1'b1, hs);
    chk("rel_tready", rdy_s, 3'b111);

    // Basic sum and latency.
    base = out_cnt;
    cycle(3'b111, {8'd30, 8'd20, 8'd10}, 1'b1, hs);
    chk("basic_hs", hs, 3'b111);
    cycle(3'b000, 24'd0, 1'b1, hs);
    chk("basic_lat0", ov_s, 0);
    cycle(3'b000, 24'd0, 1'b1, hs);
    chk("basic_lat1", ov_s, 1);
    chk("basic_sum", od0_s, 60);
    cycle(3'b000, 24'd0, 1'b1, hs);
    chk("basic_one_beat", ov_s, 0);
    chk("basic_cnt", out_cnt - base, 1);

    // Overflow and saturation boundary.
    base = out_cnt;
    cycle(3'b111, {8'd255, 8'd255, 8'd255}, 1'b1, hs);
    cycle(3'b111, {8'd55, 8'd100, 8'd100}, 1'b1, hs);
    cycle(3'b111, {8'd56, 8'd100, 8'd100}, 1'b1, hs);
    drain();
    chk("sat_cnt", out_cnt - base, 3);

    // Skew: channel 0 fills alone, then the others catch up.
    base = out_cnt;
    for (int i = 1; i <= 4; i++) begin
      cycle(3'b001, 24'(i), 1'b1, hs);
      chk("skew_hs", hs, 3'b001);
    end
    cycle(3'b001, 24'd99, 1'b1, hs);
    chk("full_tready", rdy_s[0], 0);
    chk("full_no_hs", hs, 3'b000);
    chk("full_no_out", ov_s, 0);
    for (int i = 1; i <= 4; i++) cycle(3'b110, {8'd0, 8'(10 * i), 8'd0}, 1'b1, hs);
    drain();
    chk("skew_cnt", out_cnt - base, 4);
    chk("skew_tready", rdy_s[0], 1);

    // Backpressure: sum held stable while downstream stalls.
    base = out_cnt;
    cycle(3'b111, {8'd3, 8'd2, 8'd1}, 1'b0, hs);
    cycle(3'b111, {8'd6, 8'd5, 8'd4}, 1'b0, hs);
    cycle(3'b111, {8'd9, 8'd8, 8'd7}, 1'b0, hs);
    for (int i = 0; i < 8; i++) begin
      cycle(3'b000, 24'd0, 1'b0, hs);
      chk("bp_valid", ov_s, 1);
      chk("bp_data0", od0_s, exp_q[0]);
      chk("bp_data1", od1_s, sat8(exp_q[0]));
      chk("bp_user1", ou1_s, 0);
      chk("bp_tready", rdy_s, 3'b111);
    end
    drain();
    chk("bp_cnt", out_cnt - base, 3);

    // Reset mid-stream with two beats left in each FIFO.
    cycle(3'b111, {8'd11, 8'd12, 8'd13}, 1'b0, hs);
    cycle(3'b111, {8'd21, 8'd22, 8'd23}, 1'b0, hs);
    cycle(3'b111, {8'd31, 8'd32, 8'd33}, 1'b0, hs);
    cycle(3'b000, 24'd0, 1'b0, hs);
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) chq[c].delete();
    exp_q.delete();
    base = out_cnt;
    cycle(3'b000, 24'd0, 1'b1, hs);
    chk("mid_rst_valid", ov_s, 0);
    chk("mid_rst_data", od0_s, 0);
    chk("mid_rst_tready", rdy_s, 3'b000);
    aresetn = 1'b0;
    for (int i = 0; i < 6; i++) cycle(3'b000, 24'd0, 1'b1, hs);
    chk("mid_no_out", out_cnt - base, 0);
    cycle(3'b111, {8'd3, 8'd2, 8'd1}, 1'b1, hs);
    drain();
    chk("mid_first_sum", out_cnt - base, 1);

    // Random soak with AXI-compliant held valids.
    base = out_cnt;
    pend = '0;
    cyc  = 0;
    for (int c = 0; c < 3; c++) begin
      sent[c] = 0;
      pdat[c] = '0;
    end
    while ((sent[0] < 1000 || sent[1] < 1000 || sent[2] < 1000) && cyc < 20000) begin
      for (int c = 0; c < 3; c++) begin
        if (!pend[c] && sent[c] < 1000 && $urandom_range(3) != 0) begin
          pend[c] = 1'b1;
          pdat[c] = 8'($urandom);
        end
      end
      cycle(pend, {pdat[2], pdat[1], pdat[0]}, $urandom_range(3) != 0, hs);
      for (int c = 0; c < 3; c++) begin
        if (hs[c]) begin
          pend[c] = 1'b0;
          sent[c]++;
        end
      end
      cyc++;
    end
    chk("soak_sent", sent[0] + sent[1] + sent[2], 3000);
    drain();
    chk("soak_cnt", out_cnt - base, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
